// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller feeding the D-stage register: owns the fetch PC,
// drives a synchronous-read instruction memory, sequences start-up and halts on ecall.
module inst_fetch_ctrl #(
  parameter int unsigned     PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     HALT_INST = 32'h0000_0073
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_signal_in,
  input  logic            D_stop,
  input  logic            jump_reset,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     inst_out,
  output logic            halted,
  output logic [15:0]     fetch_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
  logic               accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next PC, next state and instruction acceptance; stall outranks redirect everywhere.
  always_comb begin
    pc_d          = pc_q;
    state_d       = state_q;
    accept        = 1'b0;
    fetch_count_d = fetch_count_q;

    if (!start_signal_in) begin
      pc_d    = RESET_PC;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          pc_d    = RESET_PC;
          state_d = RUN;
        end
        RUN: begin
          if (D_stop) begin
            pc_d = pc_q;
          end else if (jump_reset) begin
            pc_d = {jump_target[PC_W-1:2], 2'b00};
          end else begin
            pc_d   = PC_W'(pc_q + PC_W'(4));
            accept = 1'b1;
            if (imem_rdata == HALT_INST) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (D_stop) begin
            pc_d = pc_q;
          end else if (jump_reset) begin
            pc_d    = {jump_target[PC_W-1:2], 2'b00};
            state_d = RUN;
          end else begin
            state_d = HALT;
          end
        end
        HALT: begin
          pc_d = pc_q;
        end
        default: begin
          pc_d    = RESET_PC;
          state_d = IDLE;
        end
      endcase
    end

    if (accept && (fetch_count_q != {CNT_W{1'b1}})) begin
      fetch_count_d = CNT_W'(fetch_count_q + CNT_W'(1));
    end
  end

  // inst_out gated combinationally so dropping start bubbles D in the same cycle.
  assign imem_addr   = pc_d;
  assign pc_out      = pc_q;
  assign inst_out    = ((state_q == RUN) && start_signal_in) ? imem_rdata : 32'd0;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboarded bench for inst_fetch_ctrl: scripted per-cycle expectations against
// a synchronous-read memory holding mem[4k] = k+1.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk;
  logic        rst;
  logic        start_signal_in;
  logic        D_stop;
  logic        jump_reset;
  logic [7:0]  jump_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [7:0]  pc_out;
  logic [31:0] inst_out;
  logic        halted;
  logic [15:0] fetch_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] inst;
    logic        halt;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [64];

  inst_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start_signal_in (start_signal_in),
    .D_stop          (D_stop),
    .jump_reset      (jump_reset),
    .jump_target     (jump_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .inst_out        (inst_out),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr[7:2]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, queue its expectation, then compare before the next edge.
  task automatic cyc(input logic s, input logic stp, input logic jr, input logic [7:0] tgt,
                     input logic [7:0] epc, input logic [31:0] einst, input logic eh,
                     input logic [15:0] ecnt);
    exp_t e;
    @(negedge clk);
    start_signal_in = s;
    D_stop          = stp;
    jump_reset      = jr;
    jump_target     = tgt;
    sb.push_back('{pc: epc, inst: einst, halt: eh, cnt: ecnt});
    #1;
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val($sformatf("pc_out@%0t", $time), 32'(pc_out), 32'(e.pc));
      check_val($sformatf("inst_out@%0t", $time), inst_out, e.inst);
      check_val($sformatf("halted@%0t", $time), 32'(halted), 32'(e.halt));
      check_val($sformatf("fetch_count@%0t", $time), 32'(fetch_count), 32'(e.cnt));
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'(k + 1);
    rst = 1'b1; start_signal_in = 1'b0; D_stop = 1'b0; jump_reset = 1'b0; jump_target = '0;
    #1;
    check_val("rst_pc_out", 32'(pc_out), 32'h00);
    check_val("rst_inst_out", inst_out, 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_fetch_count", 32'(fetch_count), 32'd0);
    check_val("rst_imem_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // start-up and sequential fetch
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h04, 2, 0, 1);
    // three-cycle stall at 0x08
    cyc(1, 1, 0, 8'h00, 8'h08, 3, 0, 2);
    cyc(1, 1, 0, 8'h00, 8'h08, 3, 0, 2);
    cyc(1, 1, 0, 8'h00, 8'h08, 3, 0, 2);
    cyc(1, 0, 0, 8'h00, 8'h08, 3, 0, 2);
    cyc(1, 0, 0, 8'h00, 8'h0C, 4, 0, 3);
    // redirect to 0x41 (low bits dropped), then stall+jump: jump ignored
    cyc(1, 0, 1, 8'h41, 8'h10, 5, 0, 4);
    cyc(1, 1, 1, 8'h80, 8'h40, 17, 0, 4);
    cyc(1, 0, 0, 8'h00, 8'h40, 17, 0, 4);
    // jump near the top of memory and wrap past 0xFC
    cyc(1, 0, 1, 8'hF8, 8'h44, 18, 0, 5);
    cyc(1, 0, 0, 8'h00, 8'hF8, 63, 0, 5);
    cyc(1, 0, 0, 8'h00, 8'hFC, 64, 0, 6);
    mem[8] = ECALL;
    cyc(1, 0, 1, 8'h18, 8'h00, 1, 0, 7);
    // ecall at 0x20: DRAIN, HALT, then start drop returns to IDLE
    cyc(1, 0, 0, 8'h00, 8'h18, 7, 0, 7);
    cyc(1, 0, 0, 8'h00, 8'h1C, 8, 0, 8);
    cyc(1, 0, 0, 8'h00, 8'h20, ECALL, 0, 9);
    cyc(1, 0, 0, 8'h00, 8'h24, 0, 0, 10);
    cyc(1, 0, 0, 8'h00, 8'h24, 0, 1, 10);
    cyc(1, 0, 0, 8'h00, 8'h24, 0, 1, 10);
    cyc(0, 0, 0, 8'h00, 8'h24, 0, 1, 10);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 10);
    // restart, hit ecall again, redirect out of DRAIN to 0x30
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 10);
    cyc(1, 0, 1, 8'h1C, 8'h00, 1, 0, 10);
    cyc(1, 0, 0, 8'h00, 8'h1C, 8, 0, 10);
    cyc(1, 0, 0, 8'h00, 8'h20, ECALL, 0, 11);
    cyc(1, 0, 1, 8'h30, 8'h24, 0, 0, 12);
    cyc(1, 0, 0, 8'h00, 8'h30, 13, 0, 12);
    cyc(1, 0, 1, 8'h18, 8'h34, 14, 0, 13);
    cyc(1, 0, 0, 8'h00, 8'h18, 7, 0, 13);

    // asynchronous reset mid-cycle at pc 0x18
    #2;
    rst = 1'b1;
    start_signal_in = 1'b0;
    #1;
    check_val("arst_pc_out", 32'(pc_out), 32'h00);
    check_val("arst_inst_out", inst_out, 32'd0);
    check_val("arst_fetch_count", 32'(fetch_count), 32'd0);
    check_val("arst_halted", 32'(halted), 32'd0);
    check_val("arst_imem_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    // still IDLE: start gives a bubble first, then RESET_PC instruction
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    cyc(1, 0, 0, 8'h00, 8'h04, 2, 0, 1);

    if (sb.size() != 0) check_val("scoreboard_leftover", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
